// File: rtl/reg_display_scanner_if.sv
// Display bus between a register tap and the scanner:
// value in, multiplexed segments, enables and status out.
interface reg_display_scanner_if #(
   parameter int DIGITS = 4
);
   logic [31:0]       value;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              overflow;
   logic              busy;

   modport master (
      output value,
      input  seg, an, overflow, busy
   );

   modport slave (
      input  value,
      output seg, an, overflow, busy
   );
endinterface

// File: rtl/reg_display_scanner.sv
// Sequential double-dabble BCD converter feeding a
// multiplexed 7-segment scanner with leading-zero blanking.
module reg_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int LZ_BLANK    = 1
) (
   input logic             clk,
   input logic             rst_n,
   reg_display_scanner_if.slave bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } state_e;

   state_e                  state_q, state_d;
   logic [31:0]             shift_q, shift_d;
   logic [39:0]             bcd_q, bcd_d, bcd_adj;
   logic [4:0]              cnt_q, cnt_d;
   logic [DIGITS-1:0][3:0]  disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [RW-1:0]           ref_q, ref_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic [DIGITS-1:0]       blank;
   logic [3:0]              digit;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            shift_d = bus.value;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
         end
         CONV: begin
            {bcd_d, shift_d} = {bcd_adj[38:0], shift_q, 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = COMMIT;
         end
         COMMIT: begin
            disp_d  = bcd_q[4*DIGITS-1:0];
            ovf_d   = |bcd_q[39:4*DIGITS];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A digit is blank when it and every higher digit are zero.
   always_comb begin
      logic nz;
      nz    = 1'b0;
      blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz       = nz | (disp_q[i] != 4'd0);
         blank[i] = !nz && (i != 0);
      end
   end

   always_comb begin
      ref_d = ref_q + RW'(1);
      idx_d = idx_q;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      an_d  = ~(DIGITS'(1) << idx_d);
      digit = disp_q[idx_d];
      if (ovf_q)
         seg_d = 7'h40;
      else if ((LZ_BLANK != 0) && blank[idx_d])
         seg_d = 7'h00;
      else
         seg_d = dec7(digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         an_q    <= ~DIGITS'(1);
         seg_q   <= 7'h3F;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.an       = an_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_display_scanner.sv
// Bench for reg_display_scanner: two instances (blanking on/off)
// checked every cycle against an arithmetic display model.
module tb_reg_display_scanner;

   localparam int RD  = 4;
   localparam int PER = 34;
   localparam logic [6:0] SEGT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] value = '0;

   int n_assert = 0;
   int n_fail   = 0;

   int unsigned cyc     = 0;
   logic [31:0] cap     = '0;
   logic [31:0] shown   = '0;
   logic [31:0] shown_p = '0;

   reg_display_scanner_if #(.DIGITS(4)) if_lz ();
   reg_display_scanner_if #(.DIGITS(4)) if_nz ();

   assign if_lz.value = value;
   assign if_nz.value = value;

   always #5 clk = ~clk;

   reg_display_scanner #(
      .DIGITS(4), .REFRESH_DIV(RD), .LZ_BLANK(1)
   ) dut_lz (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_lz)
   );

   reg_display_scanner #(
      .DIGITS(4), .REFRESH_DIV(RD), .LZ_BLANK(0)
   ) dut_nz (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_nz)
   );

   // Model: value sampled one edge after each period start,
   // shown on the display PER edges after reset / last commit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc     <= 0;
         cap     <= '0;
         shown   <= '0;
         shown_p <= '0;
      end else begin
         shown_p <= shown;
         cyc     <= cyc + 1;
         if ((cyc + 1) % PER == 1) cap <= value;
         if ((cyc + 1) % PER == 0) shown <= cap;
      end
   end

   function automatic logic [6:0] exp_seg(
      input logic [31:0] v, input int d, input bit lz);
      longint p;
      longint lv;
      p  = 1;
      lv = longint'(v);
      for (int i = 0; i < d; i++) p = p * 10;
      if (lv >= 10000) return 7'h40;
      if (lz && d > 0 && lv < p) return 7'h00;
      return SEGT[int'((lv / p) % 10)];
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int idx;
      logic [3:0] an_e;
      @(negedge clk);
      idx  = int'((cyc / RD) % 4);
      an_e = 4'(~(4'b0001 << idx));
      chk("lz.an",   32'(if_lz.an), 32'(an_e));
      chk("nz.an",   32'(if_nz.an), 32'(an_e));
      chk("lz.seg",  32'(if_lz.seg), 32'(exp_seg(shown_p, idx, 1'b1)));
      chk("nz.seg",  32'(if_nz.seg), 32'(exp_seg(shown_p, idx, 1'b0)));
      chk("lz.busy", 32'(if_lz.busy), 32'(cyc % PER != 0));
      chk("nz.busy", 32'(if_nz.busy), 32'(cyc % PER != 0));
      chk("lz.ovf",  32'(if_lz.overflow), 32'(shown >= 10000));
      chk("nz.ovf",  32'(if_nz.overflow), 32'(shown >= 10000));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic sync_to(input int ph);
      for (int i = 0; i < 2 * PER && (cyc % PER) != ph; i++)
         step();
   endtask

   task automatic reset_now();
      rst_n = 1'b0;
      #1;
      chk("rst.busy", 32'(if_lz.busy), 32'd0);
      chk("rst.ovf",  32'(if_lz.overflow), 32'd0);
      chk("rst.an",   32'(if_lz.an), 32'b1110);
      chk("rst.seg",  32'(if_lz.seg), 32'h3F);
   endtask

   initial begin
      logic [31:0] v;
      run(3);
      rst_n = 1'b1;
      value = 32'd1234;
      run(2 * PER + 20);

      value = 32'd7;
      run(2 * PER);
      value = 32'd0;
      run(2 * PER);
      value = 32'd9999;
      run(2 * PER);
      value = 32'd10000;
      run(2 * PER);
      value = 32'hFFFF_FFFF;
      run(2 * PER);

      sync_to(0);
      value = 32'd42;
      sync_to(5);
      value = 32'd9;
      run(2 * PER + 5);

      value = 32'd10000;
      run(2 * PER);
      sync_to(12);
      reset_now();
      run(3);
      rst_n = 1'b1;
      value = 32'd305;
      run(2 * PER + 10);

      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 9999);
            2:       v = $urandom_range(0, 99);
            default: begin
               case ($urandom_range(0, 4))
                  0:       v = 32'd9999;
                  1:       v = 32'd10000;
                  2:       v = 32'd1000;
                  3:       v = 32'd0;
                  default: v = 32'hFFFF_FFFF;
               endcase
            end
         endcase
         value = v;
         run($urandom_range(3, 90));
      end
      run(2 * PER);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
